// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MBR handshake. It inserts a set number of wait states,
// performs one access on an internal word RAM, then runs a four-phase mfc handshake.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rw,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mfc,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StAck} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic unused_addr;
  assign unused_addr = ^addr[15:ADDR_W];

  assign busy = (state_q != StIdle);

  // RAM has no reset; reset forces state_q out of StAccess, so an uncommitted write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && !rw_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      data_out <= '0;
      mfc      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            addr_q  <= addr[ADDR_W-1:0];
            rw_q    <= rw;
            data_q  <= data_in;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? StAccess : StWait;
          end
        end
        StWait: begin
          if (!enable) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= 4'(cnt_q - 4'd1);
            if (cnt_q == 4'd1) begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (rw_q) begin
            data_out <= mem_q[addr_q];
          end
          state_q <= StAck;
        end
        StAck: begin
          // mfc rises one edge after the access, so data_out is already stable when it is seen.
          if (enable) begin
            mfc <= 1'b1;
          end else begin
            mfc     <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a default instance and a zero-wait-state instance,
// both checked against an array-based memory and latency model.
module tb_mem_responder;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        en    [2];
  logic        rw    [2];
  logic [15:0] addr  [2];
  logic [15:0] din   [2];
  logic [15:0] dout  [2];
  logic        mfc   [2];
  logic        busy  [2];

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_m  [2][256];
  bit          vld_m  [2][256];
  logic [15:0] dout_m [2];
  bit          dk_m   [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W0)) u_dut0 (
    .clk      (clk),
    .reset    (rst_n[0]),
    .enable   (en[0]),
    .rw       (rw[0]),
    .addr     (addr[0]),
    .data_in  (din[0]),
    .data_out (dout[0]),
    .mfc      (mfc[0]),
    .busy     (busy[0])
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W1)) u_dut1 (
    .clk      (clk),
    .reset    (rst_n[1]),
    .enable   (en[1]),
    .rw       (rw[1]),
    .addr     (addr[1]),
    .data_in  (din[1]),
    .data_out (dout[1]),
    .mfc      (mfc[1]),
    .busy     (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lat_of(input int i);
    return ((i == 0) ? W0 : W1) + 2;
  endfunction

  // Full transaction; inputs are scrambled after acceptance to prove they were latched.
  task automatic txn(input int i, input bit r, input logic [15:0] a, input logic [15:0] d,
                     input int hold);
    int unsigned lat = lat_of(i);
    logic [7:0]  w   = a[7:0];
    @(negedge clk);
    en[i] = 1'b1; rw[i] = r; addr[i] = a; din[i] = d;
    @(posedge clk); #1;
    addr[i] = 16'($urandom); din[i] = 16'($urandom); rw[i] = ~r;
    if (r) begin
      dk_m[i] = vld_m[i][w];
      if (vld_m[i][w]) dout_m[i] = mem_m[i][w];
    end else begin
      mem_m[i][w] = d;
      vld_m[i][w] = 1'b1;
    end
    for (int k = 1; k <= int'(lat); k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_after_accept", 32'(busy[i]), 32'd1);
      if (k < int'(lat)) check("mfc_early", 32'(mfc[i]), 32'd0);
      else check("mfc_latency", 32'(mfc[i]), 32'd1);
    end
    if (dk_m[i]) check("data_out", 32'(dout[i]), 32'(dout_m[i]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("mfc_hold", 32'(mfc[i]), 32'd1);
    end
    en[i] = 1'b0;
    @(posedge clk); #1;
    check("mfc_fall", 32'(mfc[i]), 32'd0);
    check("busy_idle", 32'(busy[i]), 32'd0);
  endtask

  task automatic abort_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = a; din[0] = d;
    @(posedge clk); #1;
    en[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("abort_mfc", 32'(mfc[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd0);
    end
    if (dk_m[0]) check("abort_dout", 32'(dout[0]), 32'(dout_m[0]));
  endtask

  task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = a; din[0] = d;
    @(posedge clk); #1;
    check("rst_mid_busy_before", 32'(busy[0]), 32'd1);
    rst_n[0] = 1'b0; en[0] = 1'b0;
    #1;
    check("rst_mid_mfc", 32'(mfc[0]), 32'd0);
    check("rst_mid_dout", 32'(dout[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    dout_m[0] = 16'h0; dk_m[0] = 1'b1;
    @(negedge clk);
    rst_n[0] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; din[i] = '0;
      dout_m[i] = 16'h0; dk_m[i] = 1'b1;
      for (int j = 0; j < 256; j++) begin
        vld_m[i][j] = 1'b0; mem_m[i][j] = '0;
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_mfc", 32'(mfc[i]), 32'd0);
      check("reset_busy", 32'(busy[i]), 32'd0);
      check("reset_dout", 32'(dout[i]), 32'd0);
      rst_n[i] = 1'b1;
    end

    txn(0, 1'b0, 16'h0010, 16'hBEEF, 0);
    txn(0, 1'b1, 16'h0010, 16'h0000, 5);
    check("readback_beef", 32'(dout[0]), 32'h0000BEEF);
    txn(0, 1'b0, 16'h0033, 16'h9999, 0);
    txn(0, 1'b0, 16'hFF22, 16'h1234, 0);
    txn(0, 1'b1, 16'h0022, 16'h0000, 0);
    check("wrap_1234", 32'(dout[0]), 32'h00001234);
    txn(0, 1'b1, 16'h0033, 16'h0000, 1);
    txn(0, 1'b0, 16'h0040, 16'h5555, 0);
    abort_write(16'h0040, 16'hAAAA);
    txn(0, 1'b1, 16'h0040, 16'h0000, 0);
    check("abort_keeps_5555", 32'(dout[0]), 32'h00005555);
    txn(0, 1'b0, 16'h0050, 16'h0001, 0);
    reset_mid_write(16'h0050, 16'hCAFE);
    txn(0, 1'b1, 16'h0050, 16'h0000, 0);
    check("rst_keeps_0001", 32'(dout[0]), 32'h00000001);

    txn(1, 1'b0, 16'h0001, 16'h7777, 0);
    txn(1, 1'b1, 16'h0001, 16'h0000, 0);
    check("w0_read_7777", 32'(dout[1]), 32'h00007777);

    for (int n = 0; n < 120; n++) begin
      int          i = int'($urandom_range(0, 1));
      logic [15:0] a = {8'($urandom), 8'($urandom_range(0, 15))};
      logic [15:0] d = 16'($urandom);
      if (i == 0 && $urandom_range(0, 7) == 0) abort_write(a, d);
      else txn(i, 1'($urandom), a, d, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
